pair_triple_gen: RTL and testbench
==================================

PAIR_TRIPLE_GEN -- requirements
Module: pair_triple_gen

Interface
REQ-001 SHALL have parameter NREP, default 1, number of full passes per request (legal 1..4).
REQ-002 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port req_val  in  1  request valid.
REQ-005 SHALL have port req_rdy  out  1  request ready.
REQ-006 SHALL have port req_mode  in  2  pattern class: 00 all, 01 majority-only, 10 non-majority-only, 11 treated as 00.
REQ-007 SHALL have port resp_val  out  1  pattern valid.
REQ-008 SHALL have port resp_rdy  in  1  consumer ready.
REQ-009 SHALL have ports out0, out1, out2  out  1 each  generated pattern bits.
REQ-010 SHALL have port exp  out  1  expected pair/triple detector output (1 iff at least two of out0..out2 are 1).
REQ-011 SHALL have port done  out  1  one-cycle pulse at request completion.
REQ-012 SHALL have port emit_cnt  out  6  patterns transferred for the current or most recent request.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIN.
REQ-014 SHALL assert req_rdy only in IDLE; request accepted on a cycle where req_val && req_rdy is true; on acceptance SHALL latch req_mode, clear idx (3b), pass (2b) and emit_cnt, and go to RUN.
REQ-015 SHALL in RUN drive out0=idx[2], out1=idx[1], out2=idx[0], exp=majority(idx).
REQ-016 SHALL assert resp_val in RUN iff idx matches the latched mode (01: exp=1; 10: exp=0; 00/11: always).
REQ-017 SHALL advance idx when idx does not match (skip, no transfer) or when resp_val && resp_rdy (transfer), otherwise hold idx and outputs stable.
REQ-018 SHALL increment emit_cnt by 1 on each transfer; no wrap is possible for NREP<=4 (max 32).
REQ-019 SHALL on advance from idx=7 wrap idx to 0 and increment pass; if pass==NREP-1 go to FIN instead.
REQ-020 SHALL in FIN assert done for exactly one cycle, resp_val=0, then return to IDLE.
REQ-021 SHALL hold emit_cnt in FIN and IDLE until the next accepted request.
REQ-022 SHALL drive resp_val=0, done=0, out0..out2=0, exp=0 in IDLE.
REQ-023 SHALL ignore req_val/req_mode changes outside IDLE.
REQ-024 SHALL produce first pattern with zero latency: resp_val may assert the cycle after acceptance.
REQ-025 SHALL transfer 8*NREP patterns for mode 00 and 4*NREP for modes 01 and 10, in ascending idx order.

Reset
REQ-026 SHALL on reset (any state, including mid-RUN with resp_val high) enter IDLE with idx=0, pass=0, emit_cnt=0, done=0, resp_val=0, req_rdy=1 the following cycle.
REQ-027 SHALL have reset take priority over a simultaneous request handshake or response transfer.

Structure
REQ-028 SHALL place the mode encoding, FSM state enum and a majority-of-three function in shared package pair_triple_pkg.
REQ-029 SHALL compute exp in one combinational sub-module maj3 (in a,b,c; out y), instantiated once.
REQ-030 SHALL keep the FSM, idx/pass counters and emit_cnt in one always_ff block with separate combinational next-state/output logic.

Verification
REQ-031 SHALL test mode 00, NREP=1, resp_rdy=1 constantly -> patterns 000..111 on consecutive cycles, exp 0,0,0,1,0,1,1,1, done one cycle after the last transfer, emit_cnt=8.
REQ-032 SHALL test mode 01, resp_rdy=1 -> only 011,101,110,111 transferred with exp=1, skip cycles show resp_val=0, emit_cnt=4.
REQ-033 SHALL test mode 10 with resp_rdy toggling 1,0,1,0 -> 000,001,010,100 each held stable while resp_rdy=0, emit_cnt=4.
REQ-034 SHALL test NREP=2, mode 00 -> 16 transfers, second pass restarts at 000, single done pulse, emit_cnt=16.
REQ-035 SHALL test reset asserted after the third transfer of mode 00 -> next cycle req_rdy=1, resp_val=0, emit_cnt=0; new mode 01 request then completes normally with emit_cnt=4.
REQ-036 SHALL test req_val held high through RUN/FIN -> second request accepted only in IDLE after done, mode 11 behaving as 00.

Source files
------------

// File: rtl/pair_triple_pkg.sv
// pair_triple_pkg
// Shared definitions for the pair/triple pattern generator:
//   - mode_e      : request pattern class encoding
//   - state_e     : generator FSM states
//   - maj3_f      : majority-of-three helper
//   - mode_match  : decides whether a pattern belongs to the requested class
//   - width localparams for the index, pass and transfer counters
package pair_triple_pkg;

    localparam int IDX_W  = 3;
    localparam int PASS_W = 2;
    localparam int CNT_W  = 6;

    localparam logic [IDX_W-1:0] IDX_LAST = 3'd7;

    typedef enum logic [1:0] {
        MODE_ALL     = 2'b00,
        MODE_MAJ     = 2'b01,
        MODE_NONMAJ  = 2'b10,
        MODE_ALL_ALT = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } state_e;

    // True when at least two of the three inputs are set.
    function automatic logic maj3_f(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // The pattern is offered to the consumer only if it belongs to the class.
    function automatic logic mode_match(input mode_e mode, input logic maj);
        logic hit;
        case (mode)
            MODE_MAJ:    hit = maj;
            MODE_NONMAJ: hit = ~maj;
            MODE_ALL:    hit = 1'b1;
            default:     hit = 1'b1;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/pair_triple_gen_maj3.sv
// maj3
// Combinational majority-of-three voter.
// Ports:
//   a, b, c : input bits
//   y       : 1 iff at least two inputs are 1
module maj3
    import pair_triple_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    assign y = maj3_f(a, b, c);

endmodule

// File: rtl/pair_triple_gen.sv
// pair_triple_gen
// Walks all 3-bit patterns in ascending order, NREP times per request, and
// offers the ones belonging to the requested class to a valid/ready consumer
// together with the expected pair/triple detector answer.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   req_val / req_rdy  : request handshake (ready only when idle)
//   req_mode           : 00 all, 01 majority-only, 10 non-majority-only, 11 as 00
//   resp_val / resp_rdy: pattern handshake
//   out0..out2         : pattern bits (out0 is the MSB of the walk index)
//   exp                : majority of out0..out2
//   done               : one-cycle pulse after the last pass
//   emit_cnt           : patterns transferred for the current/most recent request
module pair_triple_gen
    import pair_triple_pkg::*;
#(
    parameter int NREP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [1:0]       req_mode,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic             out0,
    output logic             out1,
    output logic             out2,
    output logic             exp,
    output logic             done,
    output logic [CNT_W-1:0] emit_cnt
);

    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NREP - 1);

    state_e              state_r,    state_s;
    mode_e               mode_r,     mode_s;
    logic [IDX_W-1:0]    idx_r,      idx_s;
    logic [PASS_W-1:0]   pass_r,     pass_s;
    logic [CNT_W-1:0]    emit_cnt_r, emit_cnt_s;

    logic                req_rdy_r,  req_rdy_s;
    logic                resp_val_r, resp_val_s;
    logic [IDX_W-1:0]    out_r,      out_s;
    logic                exp_r,      exp_s;
    logic                done_r,     done_s;

    logic                maj_s;
    logic                xfer_s;
    logic                advance_s;

    // Outputs are registered, so they are derived from the next-state values;
    // the voter therefore looks at the index the walk is about to present.
    maj3 u_maj3 (
        .a (idx_s[2]),
        .b (idx_s[1]),
        .c (idx_s[0]),
        .y (maj_s)
    );

    // Next-state logic: request acceptance, index/pass walk and transfer count.
    always_comb begin
        state_s    = state_r;
        mode_s     = mode_r;
        idx_s      = idx_r;
        pass_s     = pass_r;
        emit_cnt_s = emit_cnt_r;
        xfer_s     = 1'b0;
        advance_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_val && req_rdy_r) begin
                    mode_s     = mode_e'(req_mode);
                    idx_s      = 3'd0;
                    pass_s     = 2'd0;
                    emit_cnt_s = 6'd0;
                    state_s    = ST_RUN;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_RUN: begin
                // resp_val_r is high exactly when the current index matches the
                // class, so a non-matching index is skipped without waiting.
                xfer_s    = resp_val_r & resp_rdy;
                advance_s = ~resp_val_r | resp_rdy;
                if (xfer_s) begin
                    emit_cnt_s = emit_cnt_r + 6'd1;
                end else begin
                    emit_cnt_s = emit_cnt_r;
                end
                if (advance_s) begin
                    if (idx_r == IDX_LAST) begin
                        idx_s = 3'd0;
                        if (pass_r == LAST_PASS) begin
                            pass_s  = pass_r;
                            state_s = ST_FIN;
                        end else begin
                            pass_s  = pass_r + 2'd1;
                            state_s = ST_RUN;
                        end
                    end else begin
                        idx_s   = idx_r + 3'd1;
                        state_s = ST_RUN;
                    end
                end else begin
                    idx_s   = idx_r;
                    state_s = ST_RUN;
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode of the next state, registered below.
    always_comb begin
        req_rdy_s  = 1'b0;
        resp_val_s = 1'b0;
        out_s      = 3'd0;
        exp_s      = 1'b0;
        done_s     = 1'b0;
        case (state_s)
            ST_IDLE: begin
                req_rdy_s = 1'b1;
            end
            ST_RUN: begin
                out_s      = idx_s;
                exp_s      = maj_s;
                resp_val_s = mode_match(mode_s, maj_s);
            end
            ST_FIN: begin
                done_s = 1'b1;
            end
            default: begin
                req_rdy_s = 1'b0;
            end
        endcase
    end

    // FSM, counters and registered outputs; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            mode_r     <= MODE_ALL;
            idx_r      <= 3'd0;
            pass_r     <= 2'd0;
            emit_cnt_r <= 6'd0;
            req_rdy_r  <= 1'b1;
            resp_val_r <= 1'b0;
            out_r      <= 3'd0;
            exp_r      <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            mode_r     <= mode_s;
            idx_r      <= idx_s;
            pass_r     <= pass_s;
            emit_cnt_r <= emit_cnt_s;
            req_rdy_r  <= req_rdy_s;
            resp_val_r <= resp_val_s;
            out_r      <= out_s;
            exp_r      <= exp_s;
            done_r     <= done_s;
        end
    end

    assign req_rdy  = req_rdy_r;
    assign resp_val = resp_val_r;
    assign out0     = out_r[2];
    assign out1     = out_r[1];
    assign out2     = out_r[0];
    assign exp      = exp_r;
    assign done     = done_r;
    assign emit_cnt = emit_cnt_r;

endmodule

// File: tb/tb_pair_triple_gen.sv
// tb_pair_triple_gen
// Drives an NREP=1 and an NREP=2 generator from the same inputs and compares
// both against a position-based model every cycle, plus literal expectations
// for the directed scenarios.
module tb_pair_triple_gen;

    logic       clk = 1'b0;
    logic       reset, req_val, resp_rdy;
    logic [1:0] req_mode;

    logic       r1_rdy, v1, a0, a1, a2, e1, dn1;
    logic [5:0] c1;
    logic       r2_rdy, v2, b0, b1, b2, e2, dn2;
    logic [5:0] c2;

    always #5 clk = ~clk;

    pair_triple_gen #(.NREP(1)) dut1 (
        .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(r1_rdy),
        .req_mode(req_mode), .resp_val(v1), .resp_rdy(resp_rdy),
        .out0(a0), .out1(a1), .out2(a2), .exp(e1), .done(dn1), .emit_cnt(c1)
    );

    pair_triple_gen #(.NREP(2)) dut2 (
        .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(r2_rdy),
        .req_mode(req_mode), .resp_val(v2), .resp_rdy(resp_rdy),
        .out0(b0), .out1(b1), .out2(b2), .exp(e2), .done(dn2), .emit_cnt(c2)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Model: phase 0 idle, 1 walking, 2 finishing; pos counts slots 0..8*N-1.
    int m_phase[2] = '{0, 0};
    int m_pos[2]   = '{0, 0};
    int m_mode[2]  = '{0, 0};
    int m_cnt[2]   = '{0, 0};
    int m_n[2]     = '{1, 2};
    bit started    = 1'b0;

    function automatic bit m_valid(input int mode, input int idx);
        bit mj;
        mj = ($countones(idx[2:0]) >= 2);
        if (mode == 1) return mj;
        else if (mode == 2) return !mj;
        else return 1'b1;
    endfunction

    // {req_rdy, resp_val, out0, out1, out2, exp, done, emit_cnt[5:0]}
    function automatic int m_expect(input int i);
        logic [12:0] v;
        int idx;
        v = 13'd0;
        v[5:0] = m_cnt[i][5:0];
        case (m_phase[i])
            0: v[12] = 1'b1;
            1: begin
                idx     = m_pos[i] % 8;
                v[11]   = m_valid(m_mode[i], idx);
                v[10:8] = idx[2:0];
                v[7]    = ($countones(idx[2:0]) >= 2);
            end
            2: v[6] = 1'b1;
            default: v = 13'd0;
        endcase
        return int'(v);
    endfunction

    always @(posedge clk) begin
        bit vld;
        if (reset) started <= 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_phase[i] <= 0; m_pos[i] <= 0; m_cnt[i] <= 0;
            end else begin
                case (m_phase[i])
                    0: if (req_val) begin
                        m_phase[i] <= 1; m_pos[i] <= 0; m_cnt[i] <= 0;
                        m_mode[i] <= int'(req_mode);
                    end
                    1: begin
                        vld = m_valid(m_mode[i], m_pos[i] % 8);
                        if (vld && resp_rdy) m_cnt[i] <= m_cnt[i] + 1;
                        if (!vld || resp_rdy) begin
                            m_pos[i] <= m_pos[i] + 1;
                            if (m_pos[i] + 1 == 8 * m_n[i]) m_phase[i] <= 2;
                        end
                    end
                    default: m_phase[i] <= 0;
                endcase
            end
        end
    end

    // Transfer logs hold {out0,out1,out2,exp}; xc1 holds the cycle of each.
    logic [3:0] log1[$];
    logic [3:0] log2[$];
    int xc1[$];
    int dcnt1 = 0, dcnt2 = 0, d1_last = 0;

    always @(negedge clk) begin
        #2;
        cyc++;
        if (started) begin
            check("dut1_outputs", int'({r1_rdy, v1, a0, a1, a2, e1, dn1, c1}), m_expect(0));
            check("dut2_outputs", int'({r2_rdy, v2, b0, b1, b2, e2, dn2, c2}), m_expect(1));
        end
        if (!reset && v1 && resp_rdy) begin
            log1.push_back({a0, a1, a2, e1});
            xc1.push_back(cyc);
        end
        if (!reset && v2 && resp_rdy) log2.push_back({b0, b1, b2, e2});
        if (dn1) begin dcnt1++; d1_last = cyc; end
        if (dn2) dcnt2++;
    end

    task automatic clear_logs();
        log1.delete(); log2.delete(); xc1.delete();
        dcnt1 = 0; dcnt2 = 0;
    endtask

    task automatic request(input logic [1:0] m);
        @(negedge clk);
        req_val  = 1'b1;
        req_mode = m;
        @(negedge clk);
        req_val  = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input bit toggle);
        int n;
        n = 0;
        while (!(r1_rdy && r2_rdy) && n < maxc) begin
            @(negedge clk);
            if (toggle) resp_rdy = ~resp_rdy;
            n++;
        end
        check("wait_idle_reached", int'(r1_rdy && r2_rdy), 1);
        @(negedge clk);
    endtask

    logic [7:0] exp_tab;
    int t32[4] = '{3, 5, 6, 7};
    int t33[4] = '{0, 1, 2, 4};

    initial begin
        int n;
        exp_tab  = 8'b1110_1000;
        reset    = 1'b1;
        req_val  = 1'b0;
        req_mode = 2'b00;
        resp_rdy = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_req_rdy", int'(r1_rdy), 1);
        check("reset_resp_val", int'(v1), 0);
        check("reset_emit_cnt", int'(c1), 0);

        // Mode 00, always ready; NREP=2 instance checked on the same run.
        clear_logs();
        resp_rdy = 1'b1;
        request(2'b00);
        wait_idle(60, 1'b0);
        check("t031_count", log1.size(), 8);
        for (int k = 0; k < 8 && k < log1.size(); k++)
            check("t031_pattern", int'(log1[k]), k * 2 + int'(exp_tab[k]));
        if (xc1.size() > 0) begin
            check("t031_consecutive", xc1[xc1.size()-1] - xc1[0], 7);
            check("t031_done_latency", d1_last - xc1[xc1.size()-1], 1);
        end
        check("t031_done_pulses", dcnt1, 1);
        check("t031_emit_cnt", int'(c1), 8);
        check("t034_count", log2.size(), 16);
        if (log2.size() == 16) begin
            check("t034_restart", int'(log2[8]), 0);
            check("t034_last", int'(log2[15]), 15);
        end
        check("t034_done_pulses", dcnt2, 1);
        check("t034_emit_cnt", int'(c2), 16);

        // Mode 01: majority patterns only.
        clear_logs();
        request(2'b01);
        wait_idle(60, 1'b0);
        check("t032_count", log1.size(), 4);
        for (int k = 0; k < 4 && k < log1.size(); k++)
            check("t032_pattern", int'(log1[k]), t32[k] * 2 + 1);
        check("t032_emit_cnt", int'(c1), 4);
        check("t032_emit_cnt_n2", int'(c2), 8);

        // Mode 10 with consumer ready toggling.
        clear_logs();
        request(2'b10);
        wait_idle(80, 1'b1);
        check("t033_count", log1.size(), 4);
        for (int k = 0; k < 4 && k < log1.size(); k++)
            check("t033_pattern", int'(log1[k]), t33[k] * 2);
        check("t033_emit_cnt", int'(c1), 4);
        resp_rdy = 1'b1;

        // Reset after the third transfer, then a normal mode 01 request.
        clear_logs();
        request(2'b00);
        n = 0;
        while (c1 != 6'd3 && n < 20) begin @(negedge clk); n++; end
        check("t035_third_xfer", int'(c1), 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t035_req_rdy", int'(r1_rdy), 1);
        check("t035_resp_val", int'(v1), 0);
        check("t035_emit_cnt", int'(c1), 0);
        check("t035_emit_cnt_n2", int'(c2), 0);
        clear_logs();
        request(2'b01);
        wait_idle(60, 1'b0);
        check("t035_emit_after", int'(c1), 4);
        check("t035_count_after", log1.size(), 4);

        // req_val held high through RUN/FIN with mode 11.
        clear_logs();
        @(negedge clk);
        req_mode = 2'b11;
        req_val  = 1'b1;
        repeat (25) @(negedge clk);
        req_val = 1'b0;
        wait_idle(80, 1'b0);
        check("t036_enough_xfers", int'(log1.size() > 8), 1);
        for (int k = 0; k < 8 && k < log1.size(); k++)
            check("t036_pattern", int'(log1[k]), k * 2 + int'(exp_tab[k]));
        if (xc1.size() > 8)
            check("t036_gap", xc1[8] - xc1[7], 3);

        // Randomized traffic against the model.
        for (int r = 0; r < 400; r++) begin
            @(negedge clk);
            reset    = ($urandom_range(0, 63) == 0);
            req_val  = ($urandom_range(0, 3) == 0);
            req_mode = 2'($urandom_range(0, 3));
            resp_rdy = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        reset    = 1'b0;
        req_val  = 1'b0;
        resp_rdy = 1'b1;
        wait_idle(80, 1'b0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
